// File: rtl/div_unit_if.sv
// div_unit_if -- request/response bundle for the sequential divider.
// The is_unsigned signal exists only when DIV_UNSIGNED_EN is defined.
interface div_unit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
`ifdef DIV_UNSIGNED_EN
    logic        is_unsigned;
`endif
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

`ifdef DIV_UNSIGNED_EN
    modport master (output start, a, b, is_unsigned,
                    input  hi, lo, busy, done, div_zero);
    modport slave  (input  start, a, b, is_unsigned,
                    output hi, lo, busy, done, div_zero);
`else
    modport master (output start, a, b,
                    input  hi, lo, busy, done, div_zero);
    modport slave  (input  start, a, b,
                    output hi, lo, busy, done, div_zero);
`endif
endinterface

// File: rtl/div_unit.sv
// div_unit -- 32-bit restoring divider, one quotient bit per cycle.
// Signed truncating division by default; defining DIV_UNSIGNED_EN adds an
// is_unsigned request bit that bypasses sign handling for that operation.
//
// state  | meaning
// IDLE   | waiting for start; operands and signs latched on acceptance
// RUN    | 32 shift-subtract steps on magnitudes, one per cycle
// FINISH | sign-correct and write hi/lo, pulse done
// ZERO   | divisor was zero; pulse div_zero, hi/lo untouched
module div_unit (
    input  logic     clk,
    input  logic     reset,
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        ZERO   = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q;      // shifts dividend out the top, quotient in the bottom
    logic [31:0] rem_q;
    logic [31:0] div_q;      // divisor magnitude
    logic        q_neg_q;
    logic        r_neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        div_zero_q;

    logic        signed_mode;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    // Operand magnitudes and signs as seen at the accepting edge
    always_comb begin
`ifdef DIV_UNSIGNED_EN
        signed_mode = ~bus.is_unsigned;
`else
        signed_mode = 1'b1;
`endif
        a_neg = signed_mode & bus.a[31];
        b_neg = signed_mode & bus.b[31];
        a_mag = a_neg ? (~bus.a + 32'd1) : bus.a;
        b_mag = b_neg ? (~bus.b + 32'd1) : bus.b;
    end

    // One restoring step: 33-bit partial remainder, keep it only if non-negative
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, div_q};
        if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
    end

    // Sequencer, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            quo_q      <= 32'd0;
            rem_q      <= 32'd0;
            div_q      <= 32'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.b == 32'd0) begin
                            div_zero_q <= 1'b1;
                            state_q    <= ZERO;
                        end else begin
                            quo_q   <= a_mag;
                            rem_q   <= 32'd0;
                            div_q   <= b_mag;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            cnt_q   <= 6'd0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    lo_q    <= q_neg_q ? (~quo_q + 32'd1) : quo_q;
                    hi_q    <= r_neg_q ? (~rem_q + 32'd1) : rem_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ZERO: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed vectors with a queue-based scoreboard for div_unit.
module tb_div_unit;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    div_unit_if bus();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT reports completion
    always @(negedge clk) begin
        if (!reset && (bus.done || bus.div_zero)) begin
            check("done_and_div_zero_exclusive", {31'd0, bus.done & bus.div_zero}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion actual=done%0d/zero%0d required=none", bus.done, bus.div_zero);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("kind_div_zero", {31'd0, bus.div_zero}, {31'd0, e.zero});
                check("hi", bus.hi, e.hi);
                check("lo", bus.lo, e.lo);
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one request and wait for its completion; optionally pokes an
    // extra start mid-run which must be ignored.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                          input logic zero, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic poke);
        exp_t e;
        int   n;
        logic busy_ok;
        logic finished;
        e.zero = zero;
        e.hi   = zero ? last_hi : ehi;
        e.lo   = zero ? last_lo : elo;
        e.cyc  = cyc + (zero ? 1 : 34);
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef DIV_UNSIGNED_EN
        bus.is_unsigned = uns;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
`ifdef DIV_UNSIGNED_EN
        bus.is_unsigned = ~uns;
`endif
        busy_ok  = 1'b1;
        finished = 1'b0;
        n        = 1;
        while (!finished && n < 45) begin
            if (bus.done || bus.div_zero) begin
                finished = 1'b1;
            end else begin
                if (bus.busy !== !zero) busy_ok = 1'b0;
                if (poke && n == 5) begin
                    bus.start = 1'b1;
                    bus.a     = 32'd1;
                    bus.b     = 32'd1;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b0;
        check("completion_within_bound", {31'd0, finished}, 32'd1);
        check("busy_during_op", {31'd0, busy_ok}, 32'd1);
        if (!zero) begin
            last_hi = ehi;
            last_lo = elo;
        end
        @(negedge clk);
        check("busy_after_op", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        last_hi   = 32'd0;
        last_lo   = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
`ifdef DIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'd7,          32'd2,          1'b0, 1'b0, 32'h00000001, 32'h00000003, 1'b0);
        run_op(32'hFFFFFFF9,   32'd2,          1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(32'd7,          32'hFFFFFFFE,   1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op(32'd5,          32'd0,          1'b0, 1'b1, 32'd0,        32'd0,        1'b0);
        run_op(32'h80000000,   32'hFFFFFFFF,   1'b0, 1'b0, 32'h00000000, 32'h80000000, 1'b0);
        run_op(32'd0,          32'd5,          1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0);
        run_op(32'd100,        32'd7,          1'b0, 1'b0, 32'h00000002, 32'h0000000E, 1'b0);
        run_op(32'hFFFFFF9C,   32'hFFFFFFF9,   1'b0, 1'b0, 32'hFFFFFFFE, 32'h0000000E, 1'b0);

        // Abort a divide with reset in RUN cycle 10; start during reset ignored
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        last_hi = 32'd0;
        last_lo = 32'd0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", {31'd0, bus.busy}, 32'd0);
        run_op(32'd9,          32'd3,          1'b0, 1'b0, 32'h00000000, 32'h00000003, 1'b1);

`ifdef DIV_UNSIGNED_EN
        run_op(32'hFFFFFFFF,   32'd2,          1'b1, 1'b0, 32'h00000001, 32'h7FFFFFFF, 1'b0);
`else
        run_op(32'hFFFFFFFF,   32'd2,          1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
